// File: rtl/flash_pkg.sv
// Shared definitions for the SPI NOR flash writer: opcodes, frame width,
// status bit positions and the writer FSM state type.
package flash_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam logic [7:0] FLASH_CMD_WREN = 8'h06;
    localparam logic [7:0] FLASH_CMD_PP   = 8'h02;
    localparam logic [7:0] FLASH_CMD_RDSR = 8'h05;
    localparam logic [7:0] FLASH_CMD_SE   = 8'h20;

    // Write-in-progress bit of the status register
    localparam int unsigned STATUS_WIP = 0;

    // Widest frame shifted out: opcode + 24-bit address + data byte
    localparam int unsigned FRAME_W = 40;

    typedef enum logic [3:0] {
        ST_WAIT,
        ST_IDLE,
        ST_WREN,
        ST_GAP1,
        ST_PROG,
        ST_GAP2,
        ST_POLL,
        ST_GAP3,
        ST_DONE
    } flash_wr_state_t;

    // Left-align a command and its 32-bit payload into a frame word
    function automatic logic [FRAME_W-1:0] frame_word(input logic [7:0] cmd,
                                                      input logic [31:0] payload);
        return {cmd, payload};
    endfunction

endpackage

// File: rtl/flash_spi_shift.sv
// SPI mode-0 bit engine: shifts up to 40 bits out MSB first and shifts the
// last 8 bits of MISO in. Each bit is a low phase (MOSI driven) followed by a
// high phase; MISO is sampled on the clk edge that ends the high phase.
module flash_spi_shift
    import flash_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [5:0]         bit_count,
    input  logic [FRAME_W-1:0] data,
    input  logic               miso,
    output logic               sclk,
    output logic               mosi,
    output logic               busy,
    output logic               last,
    output logic [7:0]         read_byte
);

    logic               active;
    logic               phase;
    logic [5:0]         remaining;
    logic [FRAME_W-2:0] shift_reg;
    logic [6:0]         rx;

    // Phase generation, MOSI shifting and MISO capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active    <= 1'b0;
            phase     <= 1'b0;
            remaining <= '0;
            shift_reg <= '0;
            rx        <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
        end else if (start) begin
            active    <= 1'b1;
            phase     <= 1'b0;
            remaining <= bit_count - 6'd1;
            shift_reg <= data[FRAME_W-2:0];
            sclk      <= 1'b0;
            mosi      <= data[FRAME_W-1];
        end else if (active) begin
            if (!phase) begin
                phase <= 1'b1;
                sclk  <= 1'b1;
            end else begin
                phase <= 1'b0;
                sclk  <= 1'b0;
                rx    <= {rx[5:0], miso};
                if (remaining == '0) begin
                    active <= 1'b0;
                    mosi   <= 1'b0;
                end else begin
                    remaining <= remaining - 6'd1;
                    mosi      <= shift_reg[FRAME_W-2];
                    shift_reg <= {shift_reg[FRAME_W-3:0], 1'b0};
                end
            end
        end
    end

    assign busy = active;
    assign last = active && phase && (remaining == '0);
    // Complete byte including the bit being sampled this cycle; valid while last=1
    assign read_byte = {rx, miso};

endmodule

// File: rtl/flash_writer.sv
// Single-byte SPI NOR flash programmer: WREN, PAGE PROGRAM, then RDSR polling
// until WIP clears (done) or the poll limit is hit (error).
// Optional feature macro: FLASH_WRITER_ERASE_EN adds the erase port, which
// turns the program frame into a 4 KB sector erase (0x20 + address).
module flash_writer
    import flash_pkg::*;
#(
    parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
    parameter int unsigned CS_GAP       = 4,
    parameter logic [31:0] POLL_LIMIT   = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        flashClk,
    output logic        flashMosi,
    input  logic        flashMiso,
    output logic        flashCs,
    input  logic [23:0] addr,
    input  logic [7:0]  byteWrite,
`ifdef FLASH_WRITER_ERASE_EN
    input  logic        erase,
`endif
    input  logic        enable,
    output logic        busy,
    output logic        done,
    output logic        error
);

    flash_wr_state_t    state, next_state;
    logic [31:0]        startup_cnt;
    logic [31:0]        gap_cnt;
    logic [31:0]        poll_cnt;
    logic [23:0]        addr_q;
    logic [7:0]         data_q;
`ifdef FLASH_WRITER_ERASE_EN
    logic               erase_q;
`endif
    logic               cs_q, busy_q, done_q, error_q;

    logic               shift_start;
    logic [5:0]         shift_bits;
    logic [FRAME_W-1:0] shift_data;
    logic               shift_busy;
    logic               shift_last;
    logic [7:0]         status_byte;
    logic               status_unused;

    logic               startup_over;
    logic               gap_over;
    logic               poll_exhausted;
    logic               accept;
    logic               done_set, error_set;

    flash_spi_shift u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (shift_start),
        .bit_count (shift_bits),
        .data      (shift_data),
        .miso      (flashMiso),
        .sclk      (flashClk),
        .mosi      (flashMosi),
        .busy      (shift_busy),
        .last      (shift_last),
        .read_byte (status_byte)
    );

    // Only the WIP bit steers the FSM; the rest of the status is don't-care
    assign status_unused  = ^status_byte;
    assign startup_over   = ({1'b0, startup_cnt} + 33'd1) >= {1'b0, STARTUP_WAIT};
    assign gap_over       = (gap_cnt + 32'd1) >= 32'(CS_GAP);
    assign poll_exhausted = ({1'b0, poll_cnt} + 33'd1) >= {1'b0, POLL_LIMIT};

    // Next-state decode and frame launch
    always_comb begin
        next_state  = state;
        shift_start = 1'b0;
        shift_bits  = '0;
        shift_data  = '0;
        accept      = 1'b0;
        done_set    = 1'b0;
        error_set   = 1'b0;
        case (state)
            ST_WAIT: begin
                if (startup_over) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (enable && !shift_busy) begin
                    accept      = 1'b1;
                    next_state  = ST_WREN;
                    shift_start = 1'b1;
                    shift_bits  = 6'd8;
                    shift_data  = frame_word(FLASH_CMD_WREN, 32'h0);
                end
            end
            ST_WREN: begin
                if (shift_last) next_state = ST_GAP1;
            end
            ST_GAP1: begin
                if (gap_over && !shift_busy) begin
                    next_state  = ST_PROG;
                    shift_start = 1'b1;
                    shift_bits  = 6'd40;
                    shift_data  = frame_word(FLASH_CMD_PP, {addr_q, data_q});
`ifdef FLASH_WRITER_ERASE_EN
                    if (erase_q) begin
                        shift_bits = 6'd32;
                        shift_data = frame_word(FLASH_CMD_SE, {addr_q, 8'h00});
                    end
`endif
                end
            end
            ST_PROG: begin
                if (shift_last) next_state = ST_GAP2;
            end
            ST_GAP2, ST_GAP3: begin
                if (gap_over && !shift_busy) begin
                    next_state  = ST_POLL;
                    shift_start = 1'b1;
                    shift_bits  = 6'd16;
                    shift_data  = frame_word(FLASH_CMD_RDSR, 32'h0);
                end
            end
            ST_POLL: begin
                // Decision uses the status bit sampled on this very edge
                if (shift_last) begin
                    if (!status_byte[STATUS_WIP]) begin
                        next_state = ST_DONE;
                        done_set   = 1'b1;
                    end else if (poll_exhausted) begin
                        next_state = ST_DONE;
                        error_set  = 1'b1;
                    end else begin
                        next_state = ST_GAP3;
                    end
                end
            end
            ST_DONE: begin
                if (!enable) next_state = ST_IDLE;
            end
            default: next_state = ST_WAIT;
        endcase
    end

    // State register, counters, captured request and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_WAIT;
            startup_cnt <= '0;
            gap_cnt     <= '0;
            poll_cnt    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
`ifdef FLASH_WRITER_ERASE_EN
            erase_q     <= 1'b0;
`endif
            cs_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state <= next_state;

            if (state == ST_WAIT) startup_cnt <= startup_cnt + 32'd1;

            if (state == ST_GAP1 || state == ST_GAP2 || state == ST_GAP3)
                gap_cnt <= gap_cnt + 32'd1;
            else
                gap_cnt <= '0;

            if (accept) begin
                poll_cnt <= '0;
                addr_q   <= addr;
                data_q   <= byteWrite;
`ifdef FLASH_WRITER_ERASE_EN
                erase_q  <= erase;
`endif
            end else if (state == ST_POLL && next_state == ST_GAP3) begin
                poll_cnt <= poll_cnt + 32'd1;
            end

            cs_q   <= !(next_state == ST_WREN || next_state == ST_PROG ||
                        next_state == ST_POLL);
            busy_q <= (next_state == ST_WREN || next_state == ST_GAP1 ||
                       next_state == ST_PROG || next_state == ST_GAP2 ||
                       next_state == ST_POLL || next_state == ST_GAP3);
            // Result flags are held for the whole DONE stay, cleared on exit
            done_q  <= (next_state == ST_DONE) && ((state == ST_DONE) ? done_q  : done_set);
            error_q <= (next_state == ST_DONE) && ((state == ST_DONE) ? error_q : error_set);
        end
    end

    assign flashCs = cs_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_flash_writer.sv
// Self-checking bench for flash_writer: a behavioural SPI flash model records
// every frame and answers RDSR with a scripted WIP sequence; each transaction
// is compared against frames, gaps and latency derived from the command rules.
module tb_flash_writer;

    localparam int unsigned SW  = 10;
    localparam int unsigned GAP = 4;
    localparam int unsigned PL  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flashClk, flashMosi, flashCs;
    logic        flashMiso = 1'b0;
    logic [23:0] addr = '0;
    logic [7:0]  byteWrite = '0;
    logic        enable = 1'b0;
    logic        busy, done, error;
`ifdef FLASH_WRITER_ERASE_EN
    logic        erase = 1'b0;
`endif

    int unsigned tests = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    flash_writer #(
        .STARTUP_WAIT (32'd10),
        .CS_GAP       (4),
        .POLL_LIMIT   (32'd5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flashClk  (flashClk),
        .flashMosi (flashMosi),
        .flashMiso (flashMiso),
        .flashCs   (flashCs),
        .addr      (addr),
        .byteWrite (byteWrite),
`ifdef FLASH_WRITER_ERASE_EN
        .erase     (erase),
`endif
        .enable    (enable),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural flash model ----------------
    logic [7:0]  mosi_bytes[$];
    int unsigned frame_bits[$];
    int unsigned frame_cyc[$];
    int unsigned gap_cyc[$];
    int unsigned wip_polls = 0;

    logic        prev_cs = 1'b1, prev_sclk = 1'b0, gap_valid = 1'b0;
    int unsigned bit_idx = 0, low_cyc = 0, high_cyc = 0, poll_idx = 0;
    logic [7:0]  cur_byte = '0, opcode = '0, cur_status = '0;

    always @(negedge clk) begin
        if (!flashCs) begin
            if (prev_cs) begin
                if (gap_valid) gap_cyc.push_back(high_cyc);
                else poll_idx = 0;
                bit_idx    = 0;
                low_cyc    = 0;
                opcode     = '0;
                cur_status = {7'($urandom), (poll_idx < wip_polls) ? 1'b1 : 1'b0};
            end
            low_cyc++;
            if (flashClk && !prev_sclk) begin
                cur_byte = {cur_byte[6:0], flashMosi};
                if (bit_idx % 8 == 7) begin
                    mosi_bytes.push_back(cur_byte);
                    if (bit_idx == 7) opcode = cur_byte;
                end
                if (opcode == 8'h05 && bit_idx >= 8 && bit_idx < 16)
                    flashMiso = cur_status[15 - bit_idx];
                else
                    flashMiso = 1'($urandom);
                bit_idx++;
            end
        end else begin
            if (!prev_cs) begin
                frame_bits.push_back(bit_idx);
                frame_cyc.push_back(low_cyc);
                if (opcode == 8'h05 && bit_idx == 16) poll_idx++;
                high_cyc  = 0;
                gap_valid = 1'b1;
            end
            if (!busy) gap_valid = 1'b0;
            high_cyc++;
        end
        prev_cs   = flashCs;
        prev_sclk = flashClk;
    end

    // ---------------- one write transaction ----------------
    task automatic run_txn(input logic [23:0] a, input logic [7:0] d, input bit er,
                           input int unsigned wips, input int unsigned drop_at,
                           input int unsigned accept_edges);
        int unsigned nb, nf, ng, k, npolls, pbits, lat, hold;
        bit          exp_err, busy_dropped;
        logic [7:0]  exp_b[$];
        int unsigned exp_bits[$];

        nb = mosi_bytes.size();
        nf = frame_bits.size();
        ng = gap_cyc.size();
        wip_polls = wips;
        addr      = a;
        byteWrite = d;
`ifdef FLASH_WRITER_ERASE_EN
        erase     = er;
`endif
        enable    = 1'b1;

        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!busy && k < 200);
        check("accept_lat", k, accept_edges);
        check("accept_cs", flashCs, 1'b0);

        exp_err = (wips >= PL);
        npolls  = exp_err ? PL : wips + 1;
        pbits   = er ? 32 : 40;
        lat     = 1 + 16 + GAP + 2 * pbits + GAP + npolls * 32 + (npolls - 1) * GAP;

        k = 1;
        busy_dropped = 1'b0;
        while (!(done || error) && k < 6000) begin
            @(negedge clk);
            if (k == drop_at) enable = 1'b0;
            @(posedge clk); #1; k++;
            if (!(done || error) && !busy) busy_dropped = 1'b1;
        end
        check("done_lat", k, lat);
        check("busy_held", busy_dropped, 1'b0);
        check("result", {done, error}, {!exp_err, exp_err});
        check("end_pins", {busy, flashCs, flashClk}, 3'b010);

        if (enable) begin
            hold = $urandom_range(1, 4);
            repeat (hold) begin
                @(posedge clk); #1;
                check("result_hold", {done, error, busy}, {!exp_err, exp_err, 1'b0});
            end
            @(negedge clk); enable = 1'b0;
        end
        @(posedge clk); #1;
        check("result_clear", {done, error}, 2'b00);

        exp_b.push_back(8'h06);
        exp_bits.push_back(8);
        if (er) begin
            exp_b.push_back(8'h20);
            exp_b.push_back(a[23:16]); exp_b.push_back(a[15:8]); exp_b.push_back(a[7:0]);
        end else begin
            exp_b.push_back(8'h02);
            exp_b.push_back(a[23:16]); exp_b.push_back(a[15:8]); exp_b.push_back(a[7:0]);
            exp_b.push_back(d);
        end
        exp_bits.push_back(pbits);
        for (int unsigned p = 0; p < npolls; p++) begin
            exp_b.push_back(8'h05);
            exp_b.push_back(8'h00);
            exp_bits.push_back(16);
        end

        check("nbytes", mosi_bytes.size() - nb, exp_b.size());
        if (mosi_bytes.size() - nb == exp_b.size())
            foreach (exp_b[i]) check($sformatf("mosi_byte%0d", i), mosi_bytes[nb + i], exp_b[i]);
        check("nframes", frame_bits.size() - nf, exp_bits.size());
        if (frame_bits.size() - nf == exp_bits.size())
            foreach (exp_bits[i]) begin
                check($sformatf("frame_bits%0d", i), frame_bits[nf + i], exp_bits[i]);
                check($sformatf("frame_cyc%0d", i), frame_cyc[nf + i], 2 * exp_bits[i]);
            end
        check("ngaps", gap_cyc.size() - ng, exp_bits.size() - 1);
        for (int unsigned i = ng; i < gap_cyc.size(); i++)
            check($sformatf("gap%0d", i - ng), gap_cyc[i], GAP);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int unsigned k;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pins", {flashCs, flashClk, flashMosi}, 3'b100);
        check("rst_flags", {busy, done, error}, 3'b000);

        // Program with startup wait and WIP clear on the first poll
        @(negedge clk); rst_n = 1'b1;
        run_txn(24'h012345, 8'hA5, 1'b0, 0, 0, SW + 1);

        // Busy flash: three WIP=1 polls then clear
        run_txn(24'h00FF00, 8'h3C, 1'b0, 3, 0, 1);

        // Timeout: WIP stuck
        run_txn(24'hABCDEF, 8'h11, 1'b0, 100, 0, 1);

        // Enable dropped during PROG; then immediate re-accept
        run_txn(24'h123456, 8'h78, 1'b0, 1, 50, 1);
        run_txn(24'hFFFFFF, 8'h00, 1'b0, 0, 0, 1);

`ifdef FLASH_WRITER_ERASE_EN
        run_txn(24'h010000, 8'h5A, 1'b1, 2, 0, 1);
`endif

        // Randomized transactions
        for (int n = 0; n < 8; n++) begin
            bit er_r;
            er_r = 1'b0;
`ifdef FLASH_WRITER_ERASE_EN
            er_r = 1'($urandom);
`endif
            run_txn(24'($urandom), 8'($urandom), er_r, $urandom_range(0, 6),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(2, 100) : 0, 1);
        end

        // Reset in the middle of PROG, at bit 20
        addr = 24'h0A0B0C; byteWrite = 8'hC3; wip_polls = 0;
        enable = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!busy && k < 200);
        check("mid_accept", k, 1);
        repeat (60) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_pins", {flashCs, flashClk, flashMosi}, 3'b100);
        check("mid_rst_flags", {busy, done, error}, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        run_txn(24'h0A0B0C, 8'hC3, 1'b0, 2, 0, SW + 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
